// File: rtl/autoc_pkg.sv
// rtl/autoc_pkg.sv - shared widths and FSM state encoding for the autocorrelation detector
package autoc_pkg;

    localparam int AC_WIDTH  = 43;
    localparam int MAG_WIDTH = AC_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

endpackage

// File: rtl/autoc_mag.sv
// rtl/autoc_mag.sv - two-stage L1 magnitude pipeline (|si| + |sq|) with strobe
module autoc_mag #(
    parameter int AC_WIDTH = autoc_pkg::AC_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic signed [AC_WIDTH-1:0] si,
    input  logic signed [AC_WIDTH-1:0] sq,
    input  logic                       in_valid,
    output logic        [AC_WIDTH:0]   mag,
    output logic                       mag_valid
);
    import autoc_pkg::*;

    logic [AC_WIDTH-1:0] abs_i;
    logic [AC_WIDTH-1:0] abs_q;
    logic                v1;

    // Unsigned result keeps the most negative input at +2^(AC_WIDTH-1) without wrap
    function automatic logic [AC_WIDTH-1:0] abs_u(input logic signed [AC_WIDTH-1:0] x);
        return x[AC_WIDTH-1] ? $unsigned(-x) : $unsigned(x);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            abs_i     <= '0;
            abs_q     <= '0;
            mag       <= '0;
            v1        <= 1'b0;
            mag_valid <= 1'b0;
        end else begin
            abs_i <= abs_u(si);
            abs_q <= abs_u(sq);
            mag   <= {1'b0, abs_i} + {1'b0, abs_q};
            if (flush) begin
                v1        <= 1'b0;
                mag_valid <= 1'b0;
            end else begin
                v1        <= in_valid;
                mag_valid <= v1;
            end
        end
    end

endmodule

// File: rtl/autoc_detect.sv
// rtl/autoc_detect.sv - threshold/run-length detector with peak report and hold-off
module autoc_detect #(
    parameter int AC_WIDTH   = autoc_pkg::AC_WIDTH,
    parameter int RUN_WIDTH  = 8,
    parameter int HOLD_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic signed [AC_WIDTH-1:0]   si,
    input  logic signed [AC_WIDTH-1:0]   sq,
    input  logic                         in_valid,
    input  logic        [AC_WIDTH:0]     thresh,
    input  logic        [RUN_WIDTH-1:0]  min_run,
    input  logic        [HOLD_WIDTH-1:0] holdoff,
    output logic                         detect,
    output logic        [AC_WIDTH:0]     peak_mag,
    output logic        [RUN_WIDTH-1:0]  peak_offset,
    output logic                         busy
);
    import autoc_pkg::*;

    logic [AC_WIDTH:0]     mag;
    logic                  mag_valid;
    state_t                state;
    logic [RUN_WIDTH-1:0]  eff_min;
    logic [RUN_WIDTH-1:0]  run_cnt;
    logic [RUN_WIDTH-1:0]  peak_idx;
    logic [AC_WIDTH:0]     peak;
    logic [HOLD_WIDTH-1:0] hold_cnt;
    logic [HOLD_WIDTH-1:0] hold_cnt_load;

    logic                  above;
    logic [RUN_WIDTH-1:0]  min_eff;
    logic [RUN_WIDTH-1:0]  run_nxt;
    logic                  new_peak;
    logic [AC_WIDTH:0]     best_mag;
    logic [RUN_WIDTH-1:0]  best_idx;

    autoc_mag #(.AC_WIDTH(AC_WIDTH)) u_mag (
        .clk       (clk),
        .rst       (rst),
        .flush     (~enable),
        .si        (si),
        .sq        (sq),
        .in_valid  (in_valid),
        .mag       (mag),
        .mag_valid (mag_valid)
    );

    // Strict compare on the peak means the earliest of equal maxima is reported
    always_comb begin
        above    = mag_valid && (mag > thresh);
        min_eff  = (min_run == '0) ? RUN_WIDTH'(1) : min_run;
        run_nxt  = run_cnt + RUN_WIDTH'(1);
        new_peak = mag > peak;
        best_mag = new_peak ? mag : peak;
        best_idx = new_peak ? run_cnt : peak_idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            detect        <= 1'b0;
            peak_mag      <= '0;
            peak_offset   <= '0;
            busy          <= 1'b0;
            eff_min       <= '0;
            run_cnt       <= '0;
            peak_idx      <= '0;
            peak          <= '0;
            hold_cnt      <= '0;
            hold_cnt_load <= '0;
        end else begin
            detect <= 1'b0;
            if (!enable) begin
                state    <= IDLE;
                busy     <= 1'b0;
                run_cnt  <= '0;
                hold_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (above) begin
                            eff_min       <= min_eff;
                            hold_cnt_load <= holdoff;
                            run_cnt       <= RUN_WIDTH'(1);
                            peak          <= mag;
                            peak_idx      <= '0;
                            busy          <= 1'b1;
                            if (min_eff == RUN_WIDTH'(1)) begin
                                detect      <= 1'b1;
                                peak_mag    <= mag;
                                peak_offset <= '0;
                                hold_cnt    <= holdoff;
                                state       <= HOLDOFF;
                            end else begin
                                state <= RUN;
                            end
                        end
                    end
                    RUN: begin
                        if (above) begin
                            run_cnt  <= run_nxt;
                            peak     <= best_mag;
                            peak_idx <= best_idx;
                            if (run_nxt == eff_min) begin
                                detect      <= 1'b1;
                                peak_mag    <= best_mag;
                                peak_offset <= best_idx;
                                hold_cnt    <= hold_cnt_load;
                                state       <= HOLDOFF;
                            end
                        end else if (mag_valid) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    HOLDOFF: begin
                        if (hold_cnt == '0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            hold_cnt <= hold_cnt - HOLD_WIDTH'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_autoc_detect.sv
// tb/tb_autoc_detect.sv - directed and randomized self-checking bench for autoc_detect
module tb_autoc_detect;
    localparam int AW = 43;
    localparam int MW = 44;
    localparam int RW = 8;
    localparam int HW = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 enable;
    logic                 in_valid;
    logic signed [AW-1:0] si;
    logic signed [AW-1:0] sq;
    logic [MW-1:0]        thresh;
    logic [RW-1:0]        min_run;
    logic [HW-1:0]        holdoff;
    logic                 detect;
    logic [MW-1:0]        peak_mag;
    logic [RW-1:0]        peak_offset;
    logic                 busy;

    int vec_cnt = 0;
    int err_cnt = 0;
    bit chk_en  = 1'b0;

    // Reference model state: delay line of magnitudes and the current run as a list
    bit          pv[2];
    logic [MW-1:0] pm[2];
    logic [MW-1:0] run_q[$];
    int          need;
    int          hold_load;
    bit          in_hold;
    int          hold_release;
    int          edge_n = 0;
    bit          exp_detect;
    bit          exp_busy;
    logic [MW-1:0] exp_peak;
    logic [RW-1:0] exp_off;

    autoc_detect dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .si          (si),
        .sq          (sq),
        .in_valid    (in_valid),
        .thresh      (thresh),
        .min_run     (min_run),
        .holdoff     (holdoff),
        .detect      (detect),
        .peak_mag    (peak_mag),
        .peak_offset (peak_offset),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [MW-1:0] absval(input logic signed [AW-1:0] x);
        longint v;
        v = longint'(x);
        return MW'(v < 0 ? -v : v);
    endfunction

    function automatic void model_reset();
        pv[0] = 1'b0; pv[1] = 1'b0;
        pm[0] = '0;   pm[1] = '0;
        run_q.delete();
        in_hold    = 1'b0;
        exp_detect = 1'b0;
        exp_busy   = 1'b0;
        exp_peak   = '0;
        exp_off    = '0;
    endfunction

    function automatic void model_edge();
        bit          mv;
        logic [MW-1:0] m;
        int          bi;
        edge_n++;
        mv = pv[1];
        m  = pm[1];
        exp_detect = 1'b0;
        if (!enable) begin
            pv[0] = 1'b0; pv[1] = 1'b0;
            run_q.delete();
            in_hold = 1'b0;
        end else begin
            if (in_hold) begin
                if (edge_n == hold_release) in_hold = 1'b0;
            end else if (mv) begin
                if (m > thresh) begin
                    if (run_q.size() == 0) begin
                        need      = (min_run == 0) ? 1 : int'(min_run);
                        hold_load = int'(holdoff);
                    end
                    run_q.push_back(m);
                    if (run_q.size() == need) begin
                        bi = 0;
                        for (int i = 1; i < run_q.size(); i++)
                            if (run_q[i] > run_q[bi]) bi = i;
                        exp_detect   = 1'b1;
                        exp_peak     = run_q[bi];
                        exp_off      = RW'(bi);
                        run_q.delete();
                        in_hold      = 1'b1;
                        hold_release = edge_n + hold_load + 1;
                    end
                end else begin
                    run_q.delete();
                end
            end
            pv[1] = pv[0];
            pm[1] = pm[0];
            pv[0] = in_valid;
            pm[0] = absval(si) + absval(sq);
        end
        exp_busy = in_hold || (run_q.size() != 0);
    endfunction

    task automatic cyc(input bit v, input longint a, input longint b);
        in_valid = v;
        si       = AW'(a);
        sq       = AW'(b);
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (chk_en)
            check("cycle", 64'({detect, busy, peak_offset, peak_mag}),
                           64'({exp_detect, exp_busy, exp_off, exp_peak}));
    end

    initial begin
        int d1;
        int d2;
        rst = 1'b1; enable = 1'b0; in_valid = 1'b0; si = '0; sq = '0;
        thresh = MW'(1000); min_run = RW'(3); holdoff = HW'(5);
        model_reset();
        idle(2);
        check("rst_detect", 64'(detect), 64'(0));
        check("rst_busy",   64'(busy),   64'(0));
        check("rst_peak",   64'(peak_mag), 64'(0));
        check("rst_off",    64'(peak_offset), 64'(0));
        rst = 1'b0;
        enable = 1'b1;
        chk_en = 1'b1;
        idle(3);

        // basic detection: 400, 1200, 1500, 1100
        cyc(1'b1, 400, 0); cyc(1'b1, 1200, 0); cyc(1'b1, 1500, 0); cyc(1'b1, 1100, 0);
        idle(1);
        check("t1_no_early", 64'(detect), 64'(0));
        idle(1);
        check("t1_detect", 64'(detect), 64'(1));
        check("t1_peak",   64'(peak_mag), 64'(1500));
        check("t1_off",    64'(peak_offset), 64'(1));
        check("t1_model_peak", 64'(exp_peak), 64'(1500));
        for (int i = 0; i < 5; i++) begin
            idle(1);
            check("t1_hold_busy", 64'({detect, busy}), 64'(1));
        end
        idle(1);
        check("t1_rearm", 64'(busy), 64'(0));

        // run broken by a sub-threshold sample
        cyc(1'b1, 1200, 0); cyc(1'b1, 1300, 0); cyc(1'b1, 900, 0); cyc(1'b1, 1200, 0);
        idle(1);
        check("t2_idle", 64'({detect, busy}), 64'(0));
        check("t2_peak_kept", 64'({peak_offset, peak_mag}), 64'({8'd1, 44'd1500}));
        cyc(1'b1, 100, 0);
        idle(4);

        // extremes: most negative inputs, maximal threshold, min_run=0
        thresh = MW'((longint'(1) << 43) - 1); min_run = '0; holdoff = HW'(2);
        cyc(1'b1, -(longint'(1) << 42), -(longint'(1) << 42));
        idle(2);
        check("t3_detect", 64'(detect), 64'(1));
        check("t3_peak",   64'(peak_mag), longint'(1) << 43);
        check("t3_off",    64'(peak_offset), 64'(0));
        idle(5);

        // bubbles and tie on the maximum
        thresh = MW'(1000); min_run = RW'(3); holdoff = HW'(1);
        cyc(1'b1, 2000, 0); cyc(1'b0, 0, 0); cyc(1'b1, 0, -2000); cyc(1'b0, 0, 0); cyc(1'b1, 1500, 0);
        idle(2);
        check("t4_detect", 64'(detect), 64'(1));
        check("t4_peak",   64'(peak_mag), 64'(2000));
        check("t4_off",    64'(peak_offset), 64'(0));
        idle(4);

        // samples during hold-off are ignored; re-arm spacing
        min_run = RW'(2); holdoff = HW'(4);
        d1 = -1; d2 = -1;
        for (int k = 0; k < 40 && d2 < 0; k++) begin
            cyc(1'b1, 1200 + k, 0);
            if (detect) begin
                if (d1 < 0) d1 = k;
                else        d2 = k;
            end
        end
        check("t5_rearm_gap", 64'(d2 - d1), 64'(7));
        idle(10);

        // enable drop mid-run
        min_run = RW'(5);
        cyc(1'b1, 1500, 0); cyc(1'b1, 1500, 0); cyc(1'b1, 1500, 0);
        check("t5_run_busy", 64'(busy), 64'(1));
        enable = 1'b0;
        idle(1);
        check("t5_en_idle", 64'({detect, busy}), 64'(0));
        enable = 1'b1;
        idle(4);

        // asynchronous reset during hold-off
        min_run = RW'(1); holdoff = HW'(20);
        cyc(1'b1, 5000, 0);
        idle(2);
        check("t6_detect", 64'({detect, peak_mag}), 64'({1'b1, 44'd5000}));
        idle(3);
        rst = 1'b1;
        #1;
        check("t6_async", 64'({detect, busy, peak_offset, peak_mag}), 64'(0));
        model_reset();
        idle(2);
        rst = 1'b0;
        idle(2);
        min_run = RW'(3); holdoff = HW'(3);
        cyc(1'b1, 1200, 0); cyc(1'b1, 1300, 0); cyc(1'b1, 1400, 0);
        idle(2);
        check("t6_after", 64'({detect, peak_offset, peak_mag}), 64'({1'b1, 8'd2, 44'd1400}));
        idle(6);

        // randomized traffic with live config changes
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) == 0) thresh = MW'($urandom_range(800, 1200));
            if ($urandom_range(0, 39) == 0) begin
                min_run = RW'($urandom_range(0, 4));
                holdoff = HW'($urandom_range(0, 6));
            end
            enable = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 199) == 0)
                cyc(1'b1, -(longint'(1) << 42), longint'($urandom_range(0, 5)));
            else
                cyc($urandom_range(0, 2) != 0,
                    longint'(int'($urandom_range(0, 2400)) - 1200),
                    longint'(int'($urandom_range(0, 600)) - 300));
        end
        enable = 1'b1;
        idle(20);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
